// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM encoding,
// fault detection, store byte-lane steering and load extraction.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Misalignment, out-of-range address, or a funct3 with no meaning for the access kind.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo,
                                        input logic       out_of_range);
    logic f;
    f = out_of_range;
    case (f3)
      F3_B:    f = f;
      F3_H:    if (lo[0]) f = 1'b1;
      F3_W:    if (lo != 2'b00) f = 1'b1;
      F3_BU:   if (we) f = 1'b1;
      F3_HU:   if (we || lo[0]) f = 1'b1;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lo;
      F3_H:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Data is replicated across lanes so the byte enables alone select the target bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0]  f3,
                                            input logic [31:0] word,
                                            input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    d = {{24{b[7]}}, b};
      F3_BU:   d = {24'h0, b};
      F3_H:    d = {{16{h[15]}}, h};
      F3_HU:   d = {16'h0, h};
      default: d = word;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // NOTE: the array and its read register have no reset; clearing a RAM costs a
  // write port per word and nothing downstream depends on its initial contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data memory with valid/ready request and response, programmable wait
// states and fault reporting for misaligned, out-of-range or illegal accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic              r_fault;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_fault;
  logic              w_commit;
  logic [WAW-1:0]    w_raddr;
  logic [3:0]        w_ram_we;
  logic [31:0]       w_ram_rdata;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept = req_valid && req_ready;
  assign w_fault  = access_fault(req_we, req_funct3, req_addr[1:0],
                                 req_addr >= ADDR_W'(DEPTH_BYTES));
  assign w_commit = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  // Address the RAM from the live request while idle so load data is already
  // registered by the time a zero-wait access reaches its commit edge.
  assign w_raddr  = (r_state == ST_IDLE) ? WAW'(req_addr >> 2) : WAW'(r_addr >> 2);
  assign w_ram_we = (w_commit && rst_n && r_we && !r_fault)
                    ? store_be(r_funct3, r_addr[1:0]) : 4'b0000;

  dmem_byte_ram #(
    .DEPTH_WORDS(WORDS)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_waddr(WAW'(r_addr >> 2)),
    .i_wdata(store_wdata(r_funct3, r_wdata)),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_rdata)
  );

  // Request capture needs no reset: it is only consumed after an acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_funct3 <= req_funct3;
      r_fault  <= w_fault;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register sees
  // the pre-edge values of its neighbours, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt   <= w_fault ? 4'd0 : 4'(WAIT_STATES);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_err   <= r_fault;
            r_rsp_rdata <= (r_fault || r_we) ? 32'h0
                           : load_data(r_funct3, w_ram_rdata, r_addr[1:0]);
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with WAIT_STATES = 2 and a 1 KiB array.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DEPTH_BYTES(1024),
    .WAIT_STATES(2),
    .ADDR_W     (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Drives one request, records cycles from acceptance to rsp_valid, then completes the handshake.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 40);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_timeout addr=%h got rsp_valid=%b want 1", addr, rsp_valid);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int lat;
    access(1'b1, 32'h100, 32'hDEADBEEF, F3_W, d, e, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d want=3", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL sw_err got=%b want=0", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h want=0", d); end
    access(1'b0, 32'h100, 32'h0, F3_W, d, e, lat);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", d); end
    total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d want=3", lat); end
  endtask

  task automatic test_sub_word_loads();
    logic [31:0] addrs [4] = '{32'h103, 32'h101, 32'h102, 32'h100};
    logic [2:0]  f3s   [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000BEEF};
    logic [31:0] d; logic e; int lat;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, addrs[i], 32'h0, f3s[i], d, e, lat);
      total++;
      if (d !== exps[i] || e !== 1'b0) begin
        bad++;
        $display("FAIL subword_load%0d addr=%h got=%h err=%b want=%h err=0", i, addrs[i], d, e, exps[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] d; logic e; int lat;
    access(1'b1, 32'h102, 32'h00000055, F3_B, d, e, lat);
    access(1'b0, 32'h100, 32'h0, F3_W, d, e, lat);
    total++; if (d !== 32'hDE55BEEF) begin bad++; $display("FAIL sb_merge got=%h want=de55beef", d); end
    access(1'b1, 32'h100, 32'hAAAA1234, F3_H, d, e, lat);
    access(1'b0, 32'h100, 32'h0, F3_W, d, e, lat);
    total++; if (d !== 32'hDE551234) begin bad++; $display("FAIL sh_merge got=%h want=de551234", d); end
  endtask

  task automatic test_faults();
    logic [31:0] d; logic e; int lat;
    access(1'b1, 32'h101, 32'h0000FFFF, F3_H, d, e, lat);
    total++; if (e !== 1'b1 || lat !== 1) begin bad++; $display("FAIL sh_misaligned err=%b lat=%0d want err=1 lat=1", e, lat); end
    access(1'b0, 32'h100, 32'h0, F3_W, d, e, lat);
    total++; if (d !== 32'hDE551234) begin bad++; $display("FAIL after_fault_data got=%h want=de551234", d); end
    access(1'b0, 32'h400, 32'h0, F3_W, d, e, lat);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL out_of_range err=%b data=%h want err=1 data=0", e, d); end
    access(1'b0, 32'h100, 32'h0, 3'b011, d, e, lat);
    total++; if (e !== 1'b1 || lat !== 1) begin bad++; $display("FAIL load_f3_011 err=%b lat=%0d want err=1 lat=1", e, lat); end
    access(1'b0, 32'h102, 32'h0, F3_W, d, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL lw_misaligned err=%b want=1", e); end
    access(1'b1, 32'h100, 32'hFFFFFFFF, F3_BU, d, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL store_f3_100 err=%b want=1", e); end
    access(1'b0, 32'h3FC, 32'h0, F3_HU, d, e, lat);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL lhu_last_word err=%b want=0", e); end
    access(1'b0, 32'h100, 32'h0, F3_W, d, e, lat);
    total++; if (d !== 32'hDE551234) begin bad++; $display("FAIL after_store_fault got=%h want=de551234", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; int lat; int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_funct3 = F3_W;
    @(posedge clk);
    #1;
    req_we = 1'b1; req_wdata = 32'h0;
    guard = 0;
    while (!rsp_valid && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE551234 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d valid=%b data=%h err=%b ready=%b want 1 de551234 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL bp_release valid=%b data=%h want 0 0", rsp_valid, rsp_rdata); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_no_second valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    access(1'b0, 32'h100, 32'h0, F3_W, d, e, lat);
    total++; if (d !== 32'hDE551234) begin bad++; $display("FAIL bp_store_dropped got=%h want=de551234", d); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d; logic e; int lat;
    access(1'b1, 32'h200, 32'h11223344, F3_W, d, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'hCAFEF00D; req_funct3 = F3_W;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs ready=%b valid=%b data=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h200, 32'h0, F3_W, d, e, lat);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL mid_reset_write_blocked got=%h want=11223344", d); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_sub_word_loads();
    test_partial_store();
    test_faults();
    test_backpressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
